// File: rtl/eth_rx_key_extract.sv
// eth_rx_key_extract: on-the-fly Eth/IPv4/TCP|UDP header parser.
// Emits a 96-bit flow key strobe per good frame plus frame statistics.
module eth_rx_key_extract #(
    parameter int KEY_SIZE  = 96,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk156,
    input  logic                 eth_rst_n,
    input  logic                 s_axis_tvalid,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [KEY_SIZE-1:0]  in_key,
    output logic [3:0]           in_flag,
    output logic                 in_valid,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0] stat_keys,
    output logic [CNT_WIDTH-1:0] stat_skip,
    output logic [CNT_WIDTH-1:0] stat_err,
    output logic [7:0]           debug
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t      state;
    logic [2:0]  beat_cnt;

    logic [15:0] etype_q,  etype_c;
    logic [7:0]  verihl_q, verihl_c;
    logic [12:0] frag_q,   frag_c;
    logic [7:0]  proto_q,  proto_c;
    logic [31:0] sip_q,    sip_c;
    logic [31:0] dip_q,    dip_c;
    logic [15:0] sport_q,  sport_c;
    logic [15:0] dport_q,  dport_c;
    logic [2:0]  tflg_q,   tflg_c;

    logic [2:0]  idx;
    logic        is_tcp;
    logic        is_udp;
    logic        runt;
    logic        keyable;
    logic        hdr_done;
    logic        beat_last;
    logic        fire;
    logic        skip;
    logic        err;
    logic        last_skip;
    logic        last_err;
    logic        unused;

    // tkeep carries no information the parser needs: frames are byte-packed
    assign unused = ^s_axis_tkeep;

    assign idx = (state == IDLE) ? 3'd0 : beat_cnt;

    // Header view including the beat presented this cycle, so a header
    // that completes on the tlast beat is judged with its final bytes
    always_comb begin
        etype_c  = etype_q;
        verihl_c = verihl_q;
        frag_c   = frag_q;
        proto_c  = proto_q;
        sip_c    = sip_q;
        dip_c    = dip_q;
        sport_c  = sport_q;
        dport_c  = dport_q;
        tflg_c   = tflg_q;
        if (state == HDR) begin
            unique case (beat_cnt)
                3'd1: begin
                    etype_c  = {s_axis_tdata[39:32], s_axis_tdata[47:40]};
                    verihl_c = s_axis_tdata[55:48];
                end
                3'd2: begin
                    frag_c  = {s_axis_tdata[36:32], s_axis_tdata[47:40]};
                    proto_c = s_axis_tdata[63:56];
                end
                3'd3: begin
                    sip_c = {s_axis_tdata[23:16], s_axis_tdata[31:24],
                             s_axis_tdata[39:32], s_axis_tdata[47:40]};
                    dip_c[31:16] = {s_axis_tdata[55:48], s_axis_tdata[63:56]};
                end
                3'd4: begin
                    dip_c[15:0] = {s_axis_tdata[7:0], s_axis_tdata[15:8]};
                    sport_c = {s_axis_tdata[23:16], s_axis_tdata[31:24]};
                    dport_c = {s_axis_tdata[39:32], s_axis_tdata[47:40]};
                end
                3'd5: begin
                    tflg_c = s_axis_tdata[58:56];
                end
                default: begin
                end
            endcase
        end
    end

    assign is_tcp = (proto_c == 8'd6);
    assign is_udp = (proto_c == 8'd17);

    // Protocol byte arrives on beat 2; before that nothing can be judged
    assign runt = (idx < 3'd2) ||
                  (is_tcp && idx < 3'd5) ||
                  (is_udp && idx < 3'd4);

    assign keyable = (etype_c == 16'h0800) && (verihl_c == 8'h45) &&
                     (frag_c == 13'd0) && (is_tcp || is_udp);

    assign hdr_done = (beat_cnt == 3'd5) || (beat_cnt == 3'd4 && is_udp);

    assign beat_last = s_axis_tvalid && s_axis_tlast;
    assign err  = beat_last && (!s_axis_tuser || runt);
    assign skip = beat_last && s_axis_tuser && !runt && !keyable;
    assign fire = beat_last && s_axis_tuser && !runt && keyable;

    // Frame walker: beat position within the current frame
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state    <= IDLE;
            beat_cnt <= 3'd0;
        end else if (s_axis_tvalid) begin
            unique case (state)
                IDLE: begin
                    if (!s_axis_tlast) begin
                        state    <= HDR;
                        beat_cnt <= 3'd1;
                    end
                end
                HDR: begin
                    if (s_axis_tlast) begin
                        state    <= IDLE;
                        beat_cnt <= 3'd0;
                    end else begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (hdr_done) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s_axis_tlast) begin
                        state    <= IDLE;
                        beat_cnt <= 3'd0;
                    end else if (beat_cnt != 3'd7) begin
                        beat_cnt <= beat_cnt + 3'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Capture header fields as their beats go by
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            etype_q  <= '0;
            verihl_q <= '0;
            frag_q   <= '0;
            proto_q  <= '0;
            sip_q    <= '0;
            dip_q    <= '0;
            sport_q  <= '0;
            dport_q  <= '0;
            tflg_q   <= '0;
        end else if (s_axis_tvalid) begin
            etype_q  <= etype_c;
            verihl_q <= verihl_c;
            frag_q   <= frag_c;
            proto_q  <= proto_c;
            sip_q    <= sip_c;
            dip_q    <= dip_c;
            sport_q  <= sport_c;
            dport_q  <= dport_c;
            tflg_q   <= tflg_c;
        end
    end

    // Key emission register, decoupled from the parser for back-to-back frames
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            in_valid <= 1'b0;
            in_key   <= '0;
            in_flag  <= 4'd0;
        end else begin
            in_valid <= fire;
            if (fire) begin
                in_key  <= {sip_c, dip_c, sport_c, dport_c};
                in_flag <= {is_tcp && (tflg_c[0] || tflg_c[2]),
                            is_tcp && tflg_c[1],
                            is_tcp,
                            is_udp};
            end
        end
    end

    // Per-frame statistics and last-outcome debug flags
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            stat_frames <= '0;
            stat_keys   <= '0;
            stat_skip   <= '0;
            stat_err    <= '0;
            last_skip   <= 1'b0;
            last_err    <= 1'b0;
        end else begin
            if (beat_last) begin
                stat_frames <= stat_frames + CNT_ONE;
                last_skip   <= skip;
                last_err    <= err;
            end
            if (fire) stat_keys <= stat_keys + CNT_ONE;
            if (skip) stat_skip <= stat_skip + CNT_ONE;
            if (err)  stat_err  <= stat_err + CNT_ONE;
        end
    end

    assign debug = {state, beat_cnt, in_valid, last_skip, last_err};

endmodule

// File: tb/tb_eth_rx_key_extract.sv
// tb_eth_rx_key_extract: directed frames, scoreboard on the key strobe.
// Expected keys are hand-computed constants queued at tlast time.
module tb_eth_rx_key_extract;

    logic         clk156 = 1'b0;
    logic         eth_rst_n = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic [63:0]  s_axis_tdata = '0;
    logic [7:0]   s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tuser = 1'b0;
    logic [95:0]  in_key;
    logic [3:0]   in_flag;
    logic         in_valid;
    logic [31:0]  stat_frames;
    logic [31:0]  stat_keys;
    logic [31:0]  stat_skip;
    logic [31:0]  stat_err;
    logic [7:0]   debug;

    eth_rx_key_extract dut (
        .clk156        (clk156),
        .eth_rst_n     (eth_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .in_key        (in_key),
        .in_flag       (in_flag),
        .in_valid      (in_valid),
        .stat_frames   (stat_frames),
        .stat_keys     (stat_keys),
        .stat_skip     (stat_skip),
        .stat_err      (stat_err),
        .debug         (debug)
    );

    always #5 clk156 = ~clk156;

    typedef struct packed {
        logic [95:0] key;
        logic [3:0]  flag;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] cyc = '0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fb [64];

    always @(posedge clk156) cyc <= cyc + 32'd1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every key strobe must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk156);
            if (eth_rst_n && in_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got key %0h expected none",
                             in_key);
                end else begin
                    e = q.pop_front();
                    chk("key", {32'd0, in_key}, {32'd0, e.key});
                    chk("flag", {124'd0, in_flag}, {124'd0, e.flag});
                    chk("latency", {96'd0, cyc}, {96'd0, e.cyc});
                end
            end
        end
    end

    task automatic build(input logic [15:0] et, input logic [7:0] vi,
                         input logic [15:0] fr, input logic [7:0] pr,
                         input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] sp, input logic [15:0] dp,
                         input logic [7:0] tf);
        for (int i = 0; i < 64; i++) fb[i] = 8'(i * 7 + 3);
        fb[12] = et[15:8];  fb[13] = et[7:0];
        fb[14] = vi;
        fb[20] = fr[15:8];  fb[21] = fr[7:0];
        fb[23] = pr;
        fb[26] = s[31:24];  fb[27] = s[23:16];
        fb[28] = s[15:8];   fb[29] = s[7:0];
        fb[30] = d[31:24];  fb[31] = d[23:16];
        fb[32] = d[15:8];   fb[33] = d[7:0];
        fb[34] = sp[15:8];  fb[35] = sp[7:0];
        fb[36] = dp[15:8];  fb[37] = dp[7:0];
        fb[47] = tf;
    endtask

    task automatic send(input int nb, input logic with_last,
                        input logic user, input int gap_beat,
                        input int gap_len, input logic exp_v,
                        input logic [95:0] ek, input logic [3:0] ef);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_beat) begin
                repeat (gap_len) begin
                    @(negedge clk156);
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                    s_axis_tuser  = 1'b0;
                end
            end
            @(negedge clk156);
            s_axis_tvalid = 1'b1;
            for (int j = 0; j < 8; j++) s_axis_tdata[8*j +: 8] = fb[8*b + j];
            s_axis_tkeep = 8'hFF;
            s_axis_tlast = with_last && (b == nb - 1);
            s_axis_tuser = s_axis_tlast ? user : 1'b0;
            if (s_axis_tlast && exp_v) begin
                e.key  = ek;
                e.flag = ef;
                e.cyc  = cyc + 32'd1;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk156);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        idle(1);
        while (q.size() != 0 && t < 20) begin
            idle(1);
            t++;
        end
        chk("drain", 128'(q.size()), 128'd0);
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk156);
        eth_rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        idle(2);
        eth_rst_n = 1'b1;
        idle(1);
    endtask

    task automatic chk_stats(input string nm, input int fr, input int ky,
                             input int sk, input int er);
        chk({nm, "_frames"}, 128'(stat_frames), 128'(fr));
        chk({nm, "_keys"},   128'(stat_keys),   128'(ky));
        chk({nm, "_skip"},   128'(stat_skip),   128'(sk));
        chk({nm, "_err"},    128'(stat_err),    128'(er));
    endtask

    initial begin
        idle(3);
        eth_rst_n = 1'b1;
        idle(1);
        chk("rst_key", 128'(in_key), 128'd0);
        chk("rst_flag", 128'(in_flag), 128'd0);
        chk("rst_valid", 128'(in_valid), 128'd0);
        chk("rst_debug", 128'(debug), 128'd0);
        chk_stats("rst", 0, 0, 0, 0);

        // UDP 10.0.0.1:1000 -> 10.0.0.2:53
        build(16'h0800, 8'h45, 16'h4000, 8'd17, 32'h0A000001, 32'h0A000002,
              16'd1000, 16'd53, 8'h00);
        send(8, 1, 1, -1, 0, 1, 96'h0A000001_0A000002_03E8_0035, 4'b0001);
        drain();
        chk_stats("udp", 1, 1, 0, 0);
        chk("key_hold", 128'(in_key), 128'h0A000001_0A000002_03E8_0035);

        // TCP SYN 192.168.1.1:40000 -> 192.168.1.2:80
        build(16'h0800, 8'h45, 16'h4000, 8'd6, 32'hC0A80101, 32'hC0A80102,
              16'd40000, 16'd80, 8'h02);
        send(8, 1, 1, -1, 0, 1, 96'hC0A80101_C0A80102_9C40_0050, 4'b0110);
        drain();
        chk_stats("tcp", 2, 2, 0, 0);

        // ARP, IHL=6, ICMP
        do_reset();
        build(16'h0806, 8'h45, 16'h0000, 8'd17, 32'h01010101, 32'h02020202,
              16'd1, 16'd2, 8'h00);
        send(8, 1, 1, -1, 0, 0, '0, '0);
        build(16'h0800, 8'h46, 16'h0000, 8'd17, 32'h01010101, 32'h02020202,
              16'd1, 16'd2, 8'h00);
        send(8, 1, 1, -1, 0, 0, '0, '0);
        build(16'h0800, 8'h45, 16'h0000, 8'd1, 32'h01010101, 32'h02020202,
              16'd1, 16'd2, 8'h00);
        send(8, 1, 1, -1, 0, 0, '0, '0);
        drain();
        chk_stats("skip", 3, 0, 3, 0);
        chk("skip_debug", 128'(debug), 128'h02);

        // Bad tuser, then 3-beat UDP runt
        do_reset();
        build(16'h0800, 8'h45, 16'h4000, 8'd17, 32'h0A000001, 32'h0A000002,
              16'd1000, 16'd53, 8'h00);
        send(8, 1, 0, -1, 0, 0, '0, '0);
        send(3, 1, 1, -1, 0, 0, '0, '0);
        drain();
        chk_stats("err", 2, 0, 0, 2);

        // Back-to-back UDP, 2-cycle gap inside frame 1
        do_reset();
        build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A010203, 32'h0A040506,
              16'd5000, 16'd6000, 8'h00);
        send(8, 1, 1, 3, 2, 1, 96'h0A010203_0A040506_1388_1770, 4'b0001);
        build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'hAC100009, 32'hAC10000A,
              16'd123, 16'd161, 8'h00);
        send(8, 1, 1, -1, 0, 1, 96'hAC100009_AC10000A_007B_00A1, 4'b0001);
        drain();
        chk_stats("b2b", 2, 2, 0, 0);

        // Reset at beat 3 of a TCP frame, then a UDP frame
        build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'hC0A80101, 32'hC0A80102,
              16'd40000, 16'd80, 8'h02);
        send(3, 0, 1, -1, 0, 0, '0, '0);
        @(negedge clk156);
        eth_rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        chk("midrst_debug", 128'(debug), 128'd0);
        chk_stats("midrst", 0, 0, 0, 0);
        idle(2);
        eth_rst_n = 1'b1;
        idle(1);
        build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h01020304, 32'h05060708,
              16'd7, 16'd9, 8'h00);
        send(8, 1, 1, -1, 0, 1, 96'h01020304_05060708_0007_0009, 4'b0001);
        drain();
        chk_stats("postrst", 1, 1, 0, 0);

        // Header-length boundaries, FIN flag, fragment, single beat
        do_reset();
        build(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A000003, 32'h0A000004,
              16'h1111, 16'h2222, 8'h00);
        send(5, 1, 1, -1, 0, 1, 96'h0A000003_0A000004_1111_2222, 4'b0001);
        build(16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000005, 32'h0A000006,
              16'h3333, 16'h4444, 8'h14);
        send(5, 1, 1, -1, 0, 0, '0, '0);
        build(16'h0800, 8'h45, 16'h4000, 8'd6, 32'hC0A80001, 32'hC0A80002,
              16'd1024, 16'd22, 8'h11);
        send(6, 1, 1, -1, 0, 1, 96'hC0A80001_C0A80002_0400_0016, 4'b1010);
        build(16'h0800, 8'h45, 16'h2001, 8'd17, 32'h0A000007, 32'h0A000008,
              16'd1, 16'd2, 8'h00);
        send(8, 1, 1, -1, 0, 0, '0, '0);
        send(1, 1, 1, -1, 0, 0, '0, '0);
        drain();
        chk_stats("edge", 5, 2, 1, 2);
        chk("edge_debug", 128'(debug), 128'h01);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_key_extract.md
Name: eth_rx_key_extract

Overview:
- Sits directly downstream of the 10G MAC RX AXI-Stream (64-bit, no backpressure) and upstream of the KV lookup engine.
- Parses Ethernet/IPv4/TCP|UDP headers on the fly and builds a 96-bit flow key plus a 4-bit flag.
- Issues the key as a single-cycle request when a good frame ends.
- Keeps per-frame statistics counters and a debug byte.

Parameters:
- KEY_SIZE, 96, key width; fixed layout {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0]}.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk156  in  1  156.25 MHz Ethernet clock; the only clock.
- eth_rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  MAC RX beat valid; no tready, every valid beat is consumed.
- s_axis_tdata  in  64  beat data; byte 0 of the beat is tdata[7:0].
- s_axis_tkeep  in  8  byte enables; contiguous from bit 0.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  on the tlast beat: 1 = good frame, 0 = FCS/PHY error.
- in_key  out  KEY_SIZE  lookup key.
- in_flag  out  4  bit0 UDP, bit1 TCP, bit2 TCP SYN, bit3 TCP FIN|RST.
- in_valid  out  1  single-cycle key strobe.
- stat_frames  out  CNT_WIDTH  frames seen (tlast beats).
- stat_keys  out  CNT_WIDTH  keys issued.
- stat_skip  out  CNT_WIDTH  good frames not keyable.
- stat_err  out  CNT_WIDTH  bad-tuser or runt frames.
- debug  out  8  {state[1:0], beat_cnt[2:0], in_valid, last_skip, last_err}.

Behaviour:
- Reset values: all outputs 0. State IDLE, beat_cnt 0.
- Byte n of the frame lives in beat k = n/8, at tdata[8*(n%8)+7 : 8*(n%8)]. Multi-byte fields are big-endian: first byte is the MSB.
- Fields extracted, with no VLAN support:
  - Ethertype: bytes 12-13.
  - Ver/IHL: byte 14.
  - Flags/frag: bytes 20-21.
  - Protocol: byte 23.
  - src_ip: bytes 26-29.
  - dst_ip: bytes 30-33.
  - src_port: 34-35.
  - dst_port: 36-37.
  - TCP flags: byte 47 (FIN = bit0, SYN = bit1, RST = bit2).
- Keyable frame requires all of:
  - Ethertype 0x0800.
  - Byte14 == 0x45.
  - Fragment offset (bytes 20-21, bits 12:0) == 0.
  - Protocol 6 (TCP) or 17 (UDP).
- States:
  - IDLE: a valid beat is beat 0; go to HDR, beat_cnt = 1.
  - HDR: capture fields beat by beat (beats 1-5). Keyability is decided after beat 4 for UDP and beat 5 for TCP, then go to DRAIN.
  - DRAIN: ignore data until tlast.
  - Any valid tlast beat returns to IDLE.
- Beats with tvalid = 0 do not advance beat_cnt. Gaps mid-frame are legal.
- On every tlast beat:
  - stat_frames += 1.
  - If tuser = 0: stat_err += 1, no key.
  - Else if tlast arrives before the header for the decided protocol is complete (runt): stat_err += 1, no key.
  - Else if not keyable: stat_skip += 1.
  - Else: stat_keys += 1, and in_valid = 1 on the next cycle for exactly one cycle.
- in_key and in_flag are registered in the same cycle as in_valid, and hold their value until the next key.
- Latency: tlast beat at cycle N gives in_valid at N+1.
- Back-to-back frames (beat 0 at N+1) are fully supported; the emission register is independent of the parser.
- A single-beat frame (tvalid & tlast in IDLE) is a runt.
- Counters wrap modulo 2^CNT_WIDTH with no saturation. Simultaneous increments of different counters are independent.
- Reset assertion mid-frame clears to IDLE immediately. No partial key is issued.
- The MAC and this block share a reset, so a frame never starts mid-stream after reset release.

Test Plan:
- UDP frame, 64 bytes, src 10.0.0.1:1000 to 10.0.0.2:53, tuser = 1 -> one in_valid cycle after tlast; in_key = 0x0A000001_0A000002_03E8_0035; in_flag = 4'b0001; stat_keys = 1.
- TCP SYN 192.168.1.1:40000 to 192.168.1.2:80 -> in_key = 0xC0A80101_C0A80102_9C40_0050; in_flag = 4'b0110.
- ARP frame (0x0806), then IPv4 with IHL = 6, then ICMP -> no in_valid; stat_skip = 3; stat_frames = 3.
- Valid UDP frame with tuser = 0 on tlast, then a 3-beat runt -> no in_valid; stat_err = 2.
- Two UDP frames back-to-back with a 2-cycle tvalid gap inside frame 1 -> two in_valid pulses with correct distinct keys; stat_keys = 2.
- Assert eth_rst_n = 0 at beat 3 of a TCP frame, release, then send a UDP frame -> only the UDP key is issued; all counters restart from 0.
